// File: rtl/dec_trigger_ctl.sv
// Debug trigger CSRs, commit-time qualification with pair chaining, and TLU request FSM.
// Optional per-trigger saturating hit counters: `define TRIGGER_HIT_CNT_EN.
module dec_trigger_ctl #(
  parameter int NTRIG     = 4,
  parameter int HIT_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  csr_wr_en,
  input  logic [1:0]            csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  input  logic                  dbg_mode,
  input  logic [NTRIG-1:0]      i0_trigger_match,
  input  logic                  i0_commit,
  output logic [NTRIG-1:0]      trig_select,
  output logic [NTRIG-1:0]      trig_match,
  output logic [NTRIG-1:0]      trig_execute,
  output logic [32*NTRIG-1:0]   trig_tdata2,
  output logic [NTRIG-1:0]      trig_hit,
  output logic                  trig_break_req,
  output logic                  trig_halt_req,
  input  logic                  trig_ack
);

  typedef enum logic {IDLE, REQ} state_t;

  logic [1:0]       tsel_q, tsel_d;
  logic [NTRIG-1:0] dmode_q, dmode_d;
  logic [NTRIG-1:0] hit_q, hit_d;
  logic [NTRIG-1:0] sel_q, sel_d;
  logic [NTRIG-1:0] act_q, act_d;
  logic [NTRIG-1:0] chain_q, chain_d;
  logic [NTRIG-1:0] mat_q, mat_d;
  logic [NTRIG-1:0] m_q, m_d;
  logic [NTRIG-1:0] exe_q, exe_d;
  logic [NTRIG-1:0] st_q, st_d;
  logic [NTRIG-1:0] ld_q, ld_d;
  logic [31:0]      td2_q [NTRIG];
  logic [31:0]      td2_d [NTRIG];

  state_t state_q, state_d;
  logic   halt_q, halt_d;

  logic [NTRIG-1:0] qual;
  logic [NTRIG-1:0] fire;
  logic             locked;
  logic             new_dmode;
  logic [31:0]      td1_rd;
  logic [31:0]      cnt_rd;

  assign qual = {NTRIG{i0_commit & ~dbg_mode}}
              & i0_trigger_match & m_q & exe_q;

  // Chained pairs fire together only when both halves match.
  assign fire[0] = chain_q[0] ? (qual[0] & qual[1]) : qual[0];
  assign fire[1] = chain_q[0] ? (qual[0] & qual[1]) : qual[1];
  assign fire[2] = chain_q[2] ? (qual[2] & qual[3]) : qual[2];
  assign fire[3] = chain_q[2] ? (qual[2] & qual[3]) : qual[3];

  assign locked    = dmode_q[tsel_q] & ~dbg_mode;
  assign new_dmode = dbg_mode ? csr_wdata[27] : dmode_q[tsel_q];

  always_comb begin
    tsel_d  = tsel_q;
    dmode_d = dmode_q;
    hit_d   = hit_q;
    sel_d   = sel_q;
    act_d   = act_q;
    chain_d = chain_q;
    mat_d   = mat_q;
    m_d     = m_q;
    exe_d   = exe_q;
    st_d    = st_q;
    ld_d    = ld_q;
    td2_d   = td2_q;
    if (csr_wr_en) begin
      unique case (csr_addr)
        2'd0: tsel_d = csr_wdata[1:0];
        2'd1: if (!locked) begin
          dmode_d[tsel_q] = new_dmode;
          hit_d[tsel_q]   = hit_q[tsel_q] & csr_wdata[20];
          sel_d[tsel_q]   = csr_wdata[19];
          act_d[tsel_q]   = csr_wdata[12] & new_dmode;
          chain_d[tsel_q] = csr_wdata[11] & ~tsel_q[0];
          mat_d[tsel_q]   = csr_wdata[7];
          m_d[tsel_q]     = csr_wdata[6];
          exe_d[tsel_q]   = csr_wdata[2];
          st_d[tsel_q]    = csr_wdata[1];
          ld_d[tsel_q]    = csr_wdata[0];
        end
        2'd2: if (!locked) td2_d[tsel_q] = csr_wdata;
        default: ;
      endcase
    end
    // A fire in the same cycle outranks a software clear.
    hit_d = hit_d | fire;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      tsel_q  <= '0;
      dmode_q <= '0;
      hit_q   <= '0;
      sel_q   <= '0;
      act_q   <= '0;
      chain_q <= '0;
      mat_q   <= '0;
      m_q     <= '0;
      exe_q   <= '0;
      st_q    <= '0;
      ld_q    <= '0;
      for (int i = 0; i < NTRIG; i++) td2_q[i] <= '0;
    end else begin
      tsel_q  <= tsel_d;
      dmode_q <= dmode_d;
      hit_q   <= hit_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      chain_q <= chain_d;
      mat_q   <= mat_d;
      m_q     <= m_d;
      exe_q   <= exe_d;
      st_q    <= st_d;
      ld_q    <= ld_d;
      td2_q   <= td2_d;
    end
  end

`ifdef TRIGGER_HIT_CNT_EN
  logic [HIT_CNT_W-1:0] cnt_q [NTRIG];
  logic [HIT_CNT_W-1:0] cnt_d [NTRIG];

  always_comb begin
    for (int i = 0; i < NTRIG; i++) begin
      cnt_d[i] = cnt_q[i];
      if (csr_wr_en && csr_addr == 2'd3 && tsel_q == 2'(i))
        cnt_d[i] = '0;
      if (fire[i] && cnt_d[i] != '1)
        cnt_d[i] = cnt_d[i] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < NTRIG; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_rd = 32'(cnt_q[tsel_q]);
`else
  assign cnt_rd = 32'({HIT_CNT_W{1'b0}});
`endif

  assign td1_rd = {4'h2, dmode_q[tsel_q], 6'b0,
                   hit_q[tsel_q], sel_q[tsel_q], 6'b0,
                   act_q[tsel_q], chain_q[tsel_q], 3'b0,
                   mat_q[tsel_q], m_q[tsel_q], 3'b0,
                   exe_q[tsel_q], st_q[tsel_q], ld_q[tsel_q]};

  always_comb begin
    csr_rdata = '0;
    unique case (csr_addr)
      2'd0: csr_rdata = {30'b0, tsel_q};
      2'd1: csr_rdata = td1_rd;
      2'd2: csr_rdata = td2_q[tsel_q];
      2'd3: csr_rdata = cnt_rd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  // Request kind is latched on entry; fires while pending only set hit bits.
  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    unique case (state_q)
      IDLE: if (|fire) begin
        state_d = REQ;
        halt_d  = |(fire & act_q);
      end
      REQ: if (trig_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_break_req = (state_q == REQ) & ~halt_q;
    trig_halt_req  = (state_q == REQ) &  halt_q;
  end

  assign trig_select  = sel_q;
  assign trig_match   = mat_q;
  assign trig_execute = exe_q;
  assign trig_hit     = hit_q;

  always_comb begin
    for (int i = 0; i < NTRIG; i++) trig_tdata2[32*i +: 32] = td2_q[i];
  end

endmodule

// File: tb/tb_dec_trigger_ctl.sv
// Directed bench for dec_trigger_ctl: CSR access, chaining, hit bits, request FSM.
// Counter checks run when TRIGGER_HIT_CNT_EN is defined.
module tb_dec_trigger_ctl;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         csr_wr_en;
  logic [1:0]   csr_addr;
  logic [31:0]  csr_wdata;
  logic [31:0]  csr_rdata;
  logic         dbg_mode;
  logic [3:0]   i0_trigger_match;
  logic         i0_commit;
  logic [3:0]   trig_select;
  logic [3:0]   trig_match;
  logic [3:0]   trig_execute;
  logic [127:0] trig_tdata2;
  logic [3:0]   trig_hit;
  logic         trig_break_req;
  logic         trig_halt_req;
  logic         trig_ack;

  int errs = 0;
  int chks = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  dec_trigger_ctl dut (
    .clk(clk), .rst_l(rst_l),
    .csr_wr_en(csr_wr_en), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .dbg_mode(dbg_mode),
    .i0_trigger_match(i0_trigger_match), .i0_commit(i0_commit),
    .trig_select(trig_select), .trig_match(trig_match),
    .trig_execute(trig_execute), .trig_tdata2(trig_tdata2),
    .trig_hit(trig_hit), .trig_break_req(trig_break_req),
    .trig_halt_req(trig_halt_req), .trig_ack(trig_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_wr_en = 1'b1;
    csr_addr  = a;
    csr_wdata = d;
    @(negedge clk);
    csr_wr_en = 1'b0;
    csr_wdata = '0;
  endtask

  task automatic rdcsr(input logic [1:0] a, output logic [31:0] d);
    csr_addr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic commit(input logic [3:0] m);
    @(negedge clk);
    i0_commit = 1'b1;
    i0_trigger_match = m;
    @(negedge clk);
    i0_commit = 1'b0;
    i0_trigger_match = '0;
  endtask

  task automatic ack();
    @(negedge clk);
    trig_ack = 1'b1;
    @(negedge clk);
    trig_ack = 1'b0;
  endtask

  initial begin
    rst_l = 1'b0;
    csr_wr_en = 1'b0;
    csr_addr = '0;
    csr_wdata = '0;
    dbg_mode = 1'b0;
    i0_trigger_match = '0;
    i0_commit = 1'b0;
    trig_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);

    rdcsr(2'd0, rd);
    chk("rst_tsel", rd, 32'h0);
    chk("rst_req", {30'b0, trig_break_req, trig_halt_req}, 32'h0);
    chk("rst_hit", {28'b0, trig_hit}, 32'h0);
    chk("rst_exe", {28'b0, trig_execute}, 32'h0);
    for (int t = 0; t < 4; t++) begin
      wr(2'd0, 32'(t));
      rdcsr(2'd0, rd);
      chk("rst_tsel_rb", rd, 32'(t));
      rdcsr(2'd1, rd);
      chk("rst_tdata1", rd, 32'h2000_0000);
      rdcsr(2'd2, rd);
      chk("rst_tdata2", rd, 32'h0);
    end

    // Chain bit drops on the odd trigger of a pair
    wr(2'd0, 32'd1);
    wr(2'd1, 32'h0000_0844);
    chk("t1_exe", {28'b0, trig_execute}, 32'h2);
    rdcsr(2'd1, rd);
    chk("t1_rb", rd, 32'h2000_0044);

    wr(2'd0, 32'd0);
    wr(2'd1, 32'h0000_0844);
    rdcsr(2'd1, rd);
    chk("t0_rb", rd, 32'h2000_0844);

    // Ack while idle must not raise anything
    ack();
    chk("idle_ack", {30'b0, trig_break_req, trig_halt_req}, 32'h0);

    commit(4'b0001);
    chk("half_hit", {28'b0, trig_hit}, 32'h0);
    chk("half_req", {31'b0, trig_break_req}, 32'h0);

    @(negedge clk);
    i0_commit = 1'b1;
    i0_trigger_match = 4'b0011;
    #1;
    chk("brk_lat0", {31'b0, trig_break_req}, 32'h0);
    @(negedge clk);
    i0_commit = 1'b0;
    i0_trigger_match = '0;
    chk("pair_hit", {28'b0, trig_hit}, 32'h3);
    chk("brk_up", {31'b0, trig_break_req}, 32'h1);
    chk("brk_nohalt", {31'b0, trig_halt_req}, 32'h0);
    repeat (2) @(negedge clk);
    chk("brk_hold", {31'b0, trig_break_req}, 32'h1);
    rdcsr(2'd1, rd);
    chk("t0_hitbit", rd, 32'h2010_0844);
    ack();
    chk("brk_drop", {31'b0, trig_break_req}, 32'h0);

    // Debug-mode owned trigger 2 requesting halt
    dbg_mode = 1'b1;
    wr(2'd0, 32'd2);
    wr(2'd1, 32'h0800_1044);
    wr(2'd2, 32'hDEAD_BEEF);
    rdcsr(2'd1, rd);
    chk("t2_rb", rd, 32'h2800_1044);
    chk("t2_tdata2", trig_tdata2[95:64], 32'hDEAD_BEEF);
    commit(4'b0100);
    chk("dbg_nohit", {28'b0, trig_hit}, 32'h3);
    dbg_mode = 1'b0;
    commit(4'b0100);
    chk("halt_up", {31'b0, trig_halt_req}, 32'h1);
    chk("halt_nobrk", {31'b0, trig_break_req}, 32'h0);
    chk("t2_hit", {28'b0, trig_hit}, 32'h7);
    dbg_mode = 1'b1;
    @(negedge clk);
    chk("halt_dbg_keep", {31'b0, trig_halt_req}, 32'h1);
    dbg_mode = 1'b0;

    wr(2'd1, 32'h0000_0844);
    wr(2'd2, 32'h0000_1234);
    rdcsr(2'd1, rd);
    chk("t2_locked", rd, 32'h2810_1044);
    rdcsr(2'd2, rd);
    chk("t2_td2_locked", rd, 32'hDEAD_BEEF);

    wr(2'd0, 32'd3);
    wr(2'd1, 32'h0000_0044);
    commit(4'b1000);
    chk("t3_hit", {28'b0, trig_hit}, 32'hF);
    chk("t3_halt_keep", {31'b0, trig_halt_req}, 32'h1);
    ack();
    repeat (2) @(negedge clk);
    chk("no_second_req", {30'b0, trig_break_req, trig_halt_req}, 32'h0);

    // Fire beats a same-cycle hit clear
    wr(2'd0, 32'd0);
    @(negedge clk);
    csr_wr_en = 1'b1;
    csr_addr = 2'd1;
    csr_wdata = 32'h0000_0844;
    i0_commit = 1'b1;
    i0_trigger_match = 4'b0011;
    @(negedge clk);
    csr_wr_en = 1'b0;
    i0_commit = 1'b0;
    i0_trigger_match = '0;
    chk("set_wins", {28'b0, trig_hit}, 32'hF);
    chk("set_wins_brk", {31'b0, trig_break_req}, 32'h1);
    ack();
    wr(2'd1, 32'h0000_0844);
    chk("hit0_clr", {28'b0, trig_hit}, 32'hE);

    wr(2'd0, 32'd1);
    wr(2'd1, 32'h0000_1044);
    rdcsr(2'd1, rd);
    chk("act_forced0", rd, 32'h2000_0044);
    chk("hit1_clr", {28'b0, trig_hit}, 32'hC);

    // Hit counter on trigger 0 (still chained with 1)
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h0);
    rdcsr(2'd3, rd);
    chk("cnt_clr0", rd, 32'h0);
`ifdef TRIGGER_HIT_CNT_EN
    repeat (3) commit(4'b0011);
    rdcsr(2'd3, rd);
    chk("cnt_3", rd, 32'd3);
    repeat (260) commit(4'b0011);
    rdcsr(2'd3, rd);
    chk("cnt_sat", rd, 32'd255);
    wr(2'd3, 32'h0);
    rdcsr(2'd3, rd);
    chk("cnt_clr", rd, 32'h0);
    ack();
`else
    commit(4'b0011);
    rdcsr(2'd3, rd);
    chk("cnt_absent", rd, 32'h0);
    ack();
`endif

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
